jtag_tap_sampled: RTL and testbench

//  Synthesizable IEEE 1149.1 TAP controller. It sits directly downstream of the simulation JTAG

---
 rtl/jtag_tap_sampled.sv | 129 ++++++++++++
 tb/tb_jtag_tap_sampled.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: IEEE 1149.1 TAP controller with tck oversampled in the clk domain
module jtag_tap_sampled #(
  parameter int IR_W = 5,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_W-1:0] IR_IDCODE = IR_W'(1),
  parameter logic [IR_W-1:0] IR_USER = IR_W'(8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tck,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] ir,
  output logic            user_sel,
  output logic            user_capture,
  output logic            user_shift,
  output logic            user_update,
  output logic            user_tdi,
  input  logic            user_tdo
);
  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE,
    SH_IR = 4'hA, EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } state_t;
  state_t state_q, state_d;
  logic [2:0] tck_q;
  logic [1:0] tms_q, tdi_q;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d, ir_q, ir_d;
  logic [31:0] id_q, id_d;
  logic byp_q, byp_d, tdo_q, tdo_d, tdo_en_q;
  logic cap_q, shift_q, upd_q, utdi_q;
  logic rise, fall, tms_s, tdi_s, sel_id;
  assign rise = tck_q[1] & ~tck_q[2];
  assign fall = ~tck_q[1] & tck_q[2];
  assign tms_s = tms_q[1];
  assign tdi_s = tdi_q[1];
  assign sel_id = ir_q == IR_IDCODE;
  assign user_sel = ir_q == IR_USER;
  assign tdo = tdo_q;
  assign tdo_en = tdo_en_q;
  assign tap_state = state_q;
  assign ir = ir_q;
  assign user_capture = cap_q;
  assign user_shift = shift_q;
  assign user_update = upd_q;
  assign user_tdi = utdi_q;
  // TAP state transitions, evaluated only on a synchronized tck rise
  always_comb begin
    state_d = state_q;
    if (rise)
      case (state_q)
        TLR:     state_d = tms_s ? TLR    : RTI;
        RTI:     state_d = tms_s ? SEL_DR : RTI;
        SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
        SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
        EX1_DR:  state_d = tms_s ? UPD_DR : PAU_DR;
        PAU_DR:  state_d = tms_s ? EX2_DR : PAU_DR;
        EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
        UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
        SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
        CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
        SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
        EX1_IR:  state_d = tms_s ? UPD_IR : PAU_IR;
        PAU_IR:  state_d = tms_s ? EX2_IR : PAU_IR;
        EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
        UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
  end
  // Register actions belong to the state being left on rise; tdo only moves on fall
  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d = ir_q;
    id_d = id_q;
    byp_d = byp_q;
    tdo_d = tdo_q;
    if (rise) begin
      if (state_q == CAP_IR) ir_sr_d = IR_W'(1);
      if (state_q == SH_IR) ir_sr_d = {tdi_s, ir_sr_q[IR_W-1:1]};
      if (state_q == CAP_DR) id_d = IDCODE_VAL;
      if (state_q == CAP_DR) byp_d = 1'b0;
      if (state_q == SH_DR && sel_id) id_d = {tdi_s, id_q[31:1]};
      if (state_q == SH_DR && !sel_id && !user_sel) byp_d = tdi_s;
      if (state_q == UPD_IR) ir_d = ir_sr_q;
      if (state_d == TLR) ir_d = IR_IDCODE;
    end else if (fall)
      tdo_d = state_q == SH_IR ? ir_sr_q[0] :
              state_q == SH_DR ? (sel_id ? id_q[0] : user_sel ? user_tdo : byp_q) : tdo_q;
  end
  // Synchronizers, state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
      state_q <= TLR;
      ir_sr_q <= '0;
      ir_q <= IR_IDCODE;
      id_q <= '0;
      byp_q <= 1'b0;
      tdo_q <= 1'b0;
      tdo_en_q <= 1'b0;
      cap_q <= 1'b0;
      shift_q <= 1'b0;
      upd_q <= 1'b0;
      utdi_q <= 1'b0;
    end else begin
      tck_q <= {tck_q[1:0], tck};
      tms_q <= {tms_q[0], tms};
      tdi_q <= {tdi_q[0], tdi};
      state_q <= state_d;
      ir_sr_q <= ir_sr_d;
      ir_q <= ir_d;
      id_q <= id_d;
      byp_q <= byp_d;
      tdo_q <= tdo_d;
      tdo_en_q <= state_d == SH_DR || state_d == SH_IR;
      cap_q <= rise && state_q == CAP_DR && user_sel;
      shift_q <= rise && state_q == SH_DR && user_sel;
      upd_q <= rise && state_q == UPD_DR && user_sel;
      utdi_q <= rise && state_q == SH_DR && user_sel ? tdi_s : utdi_q;
    end
  end
endmodule

// File: tb/tb_jtag_tap_sampled.sv
// tb_jtag_tap_sampled: directed and random JTAG scans against a table-driven TAP model
module tb_jtag_tap_sampled;
  logic clk, rst, tck, tms, tdi, tdo, tdo_en, user_sel;
  logic user_capture, user_shift, user_update, user_tdi, user_tdo;
  logic [3:0] tap_state;
  logic [4:0] ir;
  int tests = 0, fails = 0;
  int n_cap = 0, n_shift = 0, n_upd = 0;
  logic [5:0] utdi_rec = '0;
  logic [63:0] nxt0 = 64'hCACC_BABA_62CE_3232;
  logic [63:0] nxt1 = 64'hF977_89DD_417F_0155;
  logic [3:0] m_st;
  logic [4:0] m_ir, m_sr;

  jtag_tap_sampled dut (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .tap_state(tap_state), .ir(ir), .user_sel(user_sel), .user_capture(user_capture),
    .user_shift(user_shift), .user_update(user_update), .user_tdi(user_tdi),
    .user_tdo(user_tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (user_capture) n_cap <= n_cap + 1;
    if (user_update) n_upd <= n_upd + 1;
    if (user_shift) n_shift <= n_shift + 1;
    if (user_shift) utdi_rec <= {user_tdi, utdi_rec[5:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic ms, input logic di, input logic ut, output logic seen, output logic en);
    logic [3:0] ns;
    tms = ms;
    tdi = di;
    user_tdo = ut;
    tck = 1'b0;
    repeat (4) @(negedge clk);
    seen = tdo;
    en = tdo_en;
    tck = 1'b1;
    repeat (4) @(negedge clk);
    ns = ms ? nxt1[{m_st, 2'b00} +: 4] : nxt0[{m_st, 2'b00} +: 4];
    if (m_st == 4'hE) m_sr = 5'h01;
    else if (m_st == 4'hA) m_sr = {di, m_sr[4:1]};
    if (m_st == 4'hD) m_ir = m_sr;
    if (ns == 4'hF) m_ir = 5'h01;
    m_st = ns;
    chk("tap_state", 32'(tap_state), 32'(m_st));
  endtask

  task automatic go(input logic [7:0] seq, input int n);
    logic s, e;
    for (int i = 0; i < n; i++) tick(seq[i], 1'b0, 1'b0, s, e);
  endtask

  task automatic scan(input logic [31:0] din, input logic [31:0] uin, input int n,
                      output logic [31:0] dout, output logic en_all);
    logic s, e;
    dout = '0;
    en_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], uin[i], s, e);
      dout[i] = s;
      en_all &= e;
    end
  endtask

  initial begin
    logic [31:0] dout, din, uin;
    logic en_all;
    int c0, s0, u0;
    tck = 1'b0; tms = 1'b1; tdi = 1'b0; user_tdo = 1'b0; rst = 1'b1;
    m_st = 4'hF; m_ir = 5'h01; m_sr = 5'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", 32'(tap_state), 32'hF);
    chk("rst_ir", 32'(ir), 32'h01);
    chk("rst_tdo", 32'({tdo, tdo_en}), 32'h0);
    chk("rst_pulses", 32'({user_capture, user_shift, user_update}), 32'h0);
    go(8'b0010, 4);
    chk("to_shdr", 32'(tap_state), 32'h2);
    go(8'h1F, 5);
    chk("tlr_state", 32'(tap_state), 32'hF);
    chk("tlr_ir", 32'(ir), 32'h01);
    chk("tlr_tdo_en", 32'(tdo_en), 32'h0);
    go(8'b0010, 4);
    scan(32'h0, 32'h0, 32, dout, en_all);
    chk("idcode", dout, 32'h1000_0001);
    chk("idcode_en", 32'(en_all), 32'h1);
    go(8'b01, 2);
    go(8'b0011, 4);
    scan(32'h1F, 32'h0, 5, dout, en_all);
    chk("ir_capture", dout, 32'h01);
    chk("ir_en", 32'(en_all), 32'h1);
    go(8'b01, 2);
    chk("ir_bypass", 32'(ir), 32'h1F);
    go(8'b001, 3);
    scan(32'hA5, 32'h0, 8, dout, en_all);
    chk("bypass_dr", dout, 32'h4A);
    go(8'b01, 2);
    go(8'b0011, 4);
    scan(32'h08, 32'h0, 5, dout, en_all);
    go(8'b01, 2);
    chk("ir_user", 32'(ir), 32'h08);
    chk("user_sel", 32'(user_sel), 32'h1);
    c0 = n_cap; s0 = n_shift; u0 = n_upd;
    din = 32'($urandom_range(0, 63));
    uin = 32'($urandom_range(0, 63));
    go(8'b001, 3);
    scan(din, uin, 6, dout, en_all);
    go(8'b01, 2);
    chk("user_capture_cnt", 32'(n_cap - c0), 32'd1);
    chk("user_shift_cnt", 32'(n_shift - s0), 32'd6);
    chk("user_update_cnt", 32'(n_upd - u0), 32'd1);
    chk("user_tdi_bits", 32'(utdi_rec), din);
    chk("user_tdo_mirror", dout, uin);
    go(8'b0011, 4);
    go(8'b000, 3);
    chk("mid_shir", 32'(tap_state), 32'hA);
    tms = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'(tap_state), 32'hF);
    chk("abort_ir", 32'(ir), 32'h01);
    chk("abort_tdo_en", 32'(tdo_en), 32'h0);
    chk("abort_pulses", 32'({user_capture, user_shift, user_update}), 32'h0);
    m_st = 4'hF; m_ir = 5'h01; m_sr = 5'h00;
    for (int i = 0; i < 300; i++) begin
      logic s, e;
      tick(1'($urandom), 1'($urandom), 1'($urandom), s, e);
      chk("rand_ir", 32'(ir), 32'(m_ir));
      chk("rand_tdo_en", 32'(tdo_en), 32'(m_st == 4'h2 || m_st == 4'hA));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
